// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller.
// Contents:
//   - ALU operation code constants. The controller passes them through to the
//     shared ALU unchanged.
//   - MaxCode, the highest legal operation code.
//   - The controller state encoding.
//   - A helper that turns a requester index into a one-hot response vector.
package alu_share_ctrl_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned CodeW = 4;

  localparam logic [CodeW-1:0] OpAdd  = 4'd0;
  localparam logic [CodeW-1:0] OpSub  = 4'd1;
  localparam logic [CodeW-1:0] OpLui  = 4'd2;
  localparam logic [CodeW-1:0] OpAnd  = 4'd3;
  localparam logic [CodeW-1:0] OpXor  = 4'd4;
  localparam logic [CodeW-1:0] OpOr   = 4'd5;
  localparam logic [CodeW-1:0] OpSll  = 4'd6;
  localparam logic [CodeW-1:0] OpSrl  = 4'd7;
  localparam logic [CodeW-1:0] OpSra  = 4'd8;
  localparam logic [CodeW-1:0] OpSlt  = 4'd9;
  localparam logic [CodeW-1:0] OpSltu = 4'd10;

  localparam logic [CodeW-1:0] MaxCode = OpSltu;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Requester index to one-hot response vector.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. Purely combinational; the owner keeps the
// priority pointer register.
// Ports:
//   req    - request vector, bit i from requester i
//   ptr    - priority side when both requesters are asking
//   enable - gate; no grant is issued while low
//   gnt    - one-hot grant, or 2'b00 when idle or disabled
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       enable,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters.
// Operation:
//   - A round-robin arbiter picks one requester while the controller is idle.
//   - The controller latches that requester's operation and drives the ALU
//     for one cycle.
//   - It registers the result and holds it as a response until the granted
//     requester accepts it.
// Ports:
//   clk, rst_n               - clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready  - request handshake for requester N (ready is
//                              Mealy in IDLE)
//   reqN_code, reqN_a, reqN_b - operation code and operands of requester N
//   rsp_valid                - one-hot response owner
//   rsp_ready                - per-requester response accept
//   rsp_result, rsp_err      - registered result; err flags an illegal code
//                              (result 0)
//   alu_code, alu_a, alu_b   - to the shared ALU; they hold their last values
//                              outside EXEC
//   alu_result               - from the shared ALU
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        CODE_W   = 4,
  parameter logic [CODE_W-1:0]  MAX_CODE = 4'b1010
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CODE_W-1:0] req0_code,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CODE_W-1:0] req1_code,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,

  output logic [CODE_W-1:0] alu_code,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result
);

  state_e              state_q;
  logic                ptr_q;
  logic                gnt_idx_q;
  logic [CODE_W-1:0]   code_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [1:0]          rsp_valid_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_err_q;

  logic [1:0]          gnt;
  logic                illegal;
  logic                rsp_done;

  // Arbitration is only live in IDLE, so ready is zero in EXEC and RESP.
  rr_arb2 u_arb (
    .req    ({req1_valid, req0_valid}),
    .ptr    (ptr_q),
    .enable (state_q == StIdle),
    .gnt    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign illegal  = (code_q > MAX_CODE);
  // Only the granted requester's ready bit can complete a response.
  assign rsp_done = rsp_ready[gnt_idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      gnt_idx_q    <= 1'b0;
      code_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A grant already implies the granted requester is valid.
          if (gnt != 2'b00) begin
            gnt_idx_q <= gnt[1];
            code_q    <= gnt[1] ? req1_code : req0_code;
            a_q       <= gnt[1] ? req1_a    : req0_a;
            b_q       <= gnt[1] ? req1_b    : req0_b;
            state_q   <= StExec;
          end
        end
        StExec: begin
          if (illegal) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
          end else begin
            rsp_result_q <= alu_result;
            rsp_err_q    <= 1'b0;
          end
          rsp_valid_q <= idx_to_onehot(gnt_idx_q);
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_done) begin
            // Hand priority to the other side so contention alternates.
            ptr_q       <= ~gnt_idx_q;
            rsp_valid_q <= 2'b00;
            state_q     <= StIdle;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  // The ALU inputs come straight from the latched operation, so they only
  // change on a new grant.
  assign alu_code   = code_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_code, req1_code, alu_code;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_code  (req0_code),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_code  (req1_code),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_code   (alu_code),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  // Reference ALU standing in for the shared instance; junk for illegal codes.
  always_comb begin
    alu_result = 32'hFFFF_FFFF;
    case (alu_code)
      4'd0:  alu_result = alu_a + alu_b;
      4'd1:  alu_result = alu_a - alu_b;
      4'd2:  alu_result = alu_b;
      4'd3:  alu_result = alu_a & alu_b;
      4'd4:  alu_result = alu_a ^ alu_b;
      4'd5:  alu_result = alu_a | alu_b;
      4'd6:  alu_result = alu_a << alu_b[4:0];
      4'd7:  alu_result = alu_a >> alu_b[4:0];
      4'd8:  alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'd9:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd10: alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = 32'hFFFF_FFFF;
    endcase
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_code = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_code = '0; req1_a = '0; req1_b = '0;
    rsp_ready  = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    end
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid);
    end
    n_checks++;
    if (rsp_result !== 32'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: got %h/%b want 0/0", rsp_result, rsp_err);
    end
    n_checks++;
    if (alu_code !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      n_fail++; $display("FAIL reset_alu: got %h %h %h want 0 0 0", alu_code, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    req0_valid = 1'b1; req0_code = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
    @(negedge clk);
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL basic_ready: got %b want 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_code !== 4'd0) begin
      n_fail++; $display("FAIL basic_alu_in: got %h %h %h want 0 5 7", alu_code, alu_a, alu_b);
    end
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL basic_exec_valid: got %b want 00", rsp_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_rsp: got %b %0d %b want 01 12 0", rsp_valid, rsp_result, rsp_err);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL basic_done: got %b want 00", rsp_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_gnt [3] = '{2'b01, 2'b10, 2'b01};
    logic [31:0] exp_res [3] = '{32'd7, 32'd1, 32'd7};
    do_reset();
    req0_valid = 1'b1; req0_code = 4'd1; req0_a = 32'd10;         req0_b = 32'd3;
    req1_valid = 1'b1; req1_code = 4'd9; req1_a = 32'hFFFF_FFFF;  req1_b = 32'd1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({req1_ready, req0_ready} !== exp_gnt[i]) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got %b want %b", i, {req1_ready, req0_ready}, exp_gnt[i]);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        n_fail++; $display("FAIL b2b_exec_ready%0d: got %b want 00", i, {req1_ready, req0_ready});
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== exp_gnt[i] || rsp_result !== exp_res[i]) begin
        n_fail++;
        $display("FAIL b2b_rsp%0d: got %b %h want %b %h", i, rsp_valid, rsp_result,
                 exp_gnt[i], exp_res[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_code = 4'd0; req0_a = 32'd100; req0_b = 32'd23;
    @(negedge clk);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    tick();
    req1_valid = 1'b1; req1_code = 4'd0; req1_a = 32'd1; req1_b = 32'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 32'd123 ||
          {req1_ready, req0_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %b %0d %b want 01 123 00", k, rsp_valid, rsp_result,
                 {req1_ready, req0_ready});
      end
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00 || req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got %b %b want 00 1", rsp_valid, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_result !== 32'd3) begin
      n_fail++; $display("FAIL bp_req1_rsp: got %b %0d want 10 3", rsp_valid, rsp_result);
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_illegal();
    req1_valid = 1'b1; req1_code = 4'hF; req1_a = 32'hDEAD_BEEF; req1_b = 32'hDEAD_BEEF;
    @(negedge clk);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_rsp: got %b %h %b want 10 0 1", rsp_valid, rsp_result, rsp_err);
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    req0_valid = 1'b1; req0_code = 4'd4; req0_a = 32'hF0; req0_b = 32'h0F;
    @(negedge clk);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'hFF || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL legal_after_illegal: got %b %h %b want 01 ff 0", rsp_valid, rsp_result,
               rsp_err);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_exec();
    // Last op served was req0, so the pointer now favours req1.
    req0_valid = 1'b1; req0_code = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
    @(negedge clk);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (alu_a !== 32'd1) begin
      n_fail++; $display("FAIL rst_exec_alu: got %h want 1", alu_a);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || rsp_result !== 32'd0 || rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_async_clear: got %h %h %h %b want 0 0 0 00", alu_a, alu_b, rsp_result,
               rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 2'b00) begin
        n_fail++; $display("FAIL rst_no_rsp%0d: got %b want 00", k, rsp_valid);
      end
    end
    rsp_ready = 2'b00;
    tick();
    req0_valid = 1'b1; req0_code = 4'd0; req0_a = 32'd2; req0_b = 32'd2;
    req1_valid = 1'b1; req1_code = 4'd1; req1_a = 32'd9; req1_b = 32'd4;
    @(negedge clk);
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_ptr_grant: got %b want 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd4) begin
      n_fail++; $display("FAIL rst_next_rsp: got %b %0d want 01 4", rsp_valid, rsp_result);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_wrong_bit();
    req0_valid = 1'b1; req0_code = 4'd3; req0_a = 32'hFF; req0_b = 32'h0F;
    @(negedge clk);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    tick();
    rsp_ready = 2'b10;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 32'h0F) begin
        n_fail++; $display("FAIL wrong_bit_hold%0d: got %b %h want 01 0f", k, rsp_valid, rsp_result);
      end
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL wrong_bit_done: got %b want 00", rsp_valid);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_mid_exec();
    test_wrong_bit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one combinational 32-bit ALU between two requesters (req0, req1) through valid/ready handshakes.
- Round-robin arbitration picks a requester and registers its operation code and operands.
- Drives the shared ALU for one cycle, captures the result and returns it to the granted requester.
- Sits between the execution-stage clients (for example the main pipeline and the address/multi-cycle unit) and the single ALU instance.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU datapath.
- CODE_W, 4, width of the ALU operation code.
- MAX_CODE, 4'b1010, highest legal operation code (sltu); codes above it are illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  controller accepts requester 0 this cycle.
- req0_code  input  CODE_W  requester 0 operation code.
- req0_a  input  DATA_W  requester 0 operand A.
- req0_b  input  DATA_W  requester 0 operand B.
- req1_valid, req1_ready, req1_code, req1_a, req1_b: same as the req0 set, for requester 1.
- rsp_valid  output  2  one-hot; bit i means the response belongs to requester i.
- rsp_ready  input  2  bit i means requester i takes the response.
- rsp_result  output  DATA_W  registered ALU result.
- rsp_err  output  1  operation code was illegal; rsp_result is 0.
- alu_code  output  CODE_W  to the shared ALU operation select.
- alu_a  output  DATA_W  to the shared ALU operand A.
- alu_b  output  DATA_W  to the shared ALU operand B.
- alu_result  input  DATA_W  from the shared ALU result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, priority pointer=0.
  - req*_ready=0, rsp_valid=2'b00, rsp_result=0, rsp_err=0.
  - alu_code=0, alu_a=0, alu_b=0.
  - Any in-flight operation is dropped; no response is ever issued for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_i_ready = grant_i (combinational, Mealy).
  - grant goes to the only valid requester. If both are valid, it goes to the pointer side.
  - On handshake (valid & ready): latch code/a/b and the grant index; go to EXEC.
  - With no valid requester, stay in IDLE.
- EXEC:
  - alu_code/alu_a/alu_b driven from the latched registers; they are stable the whole cycle.
  - At the clock edge, rsp_result <= alu_result; rsp_err=0. Go to RESP.
  - Illegal code (> MAX_CODE): rsp_result <= 0 and rsp_err <= 1; the ALU output is ignored.
- RESP:
  - rsp_valid[g]=1, with rsp_result and rsp_err held stable until rsp_ready[g]=1.
  - On rsp_ready[g]: pointer <= ~g, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
  - req*_ready=0 in EXEC and RESP.
- Latency and throughput:
  - Accept at edge N, EXEC in cycle N+1, rsp_valid from cycle N+2.
  - Best-case throughput is one operation per 3 cycles.
- ALU inputs outside EXEC hold their last latched values; this avoids toggling the datapath.
- Starvation-free: after a serviced op the other requester has priority, so under continuous contention the grants alternate 0,1,0,1.
- Requesters must hold valid/code/a/b until ready. Deasserting valid before ready is allowed; the operation is simply not taken.
- Simultaneous events:
  - A new request during EXEC/RESP waits.
  - A request arriving in the same cycle that RESP completes is considered only in the following IDLE cycle; no IDLE bypass.

Decomposition:
- Shared package: ALU operation code constants (add, sub, lui, and, xor, or, sll, srl, sra, slt, sltu), MAX_CODE, and the state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- One sub-module: rr_arb2.
  - 2-input round-robin arbiter: inputs req[1:0], ptr, enable; output one-hot gnt[1:0].
  - Purely combinational; the pointer register lives in alu_share_ctrl.

Test Plan:
- Reset, then req0: code=0000, A=5, B=7 -> req0_ready=1 in cycle 0; alu_a=5 and alu_b=7 in cycle 1; rsp_valid=01 with rsp_result=12 and rsp_err=0 in cycle 2.
- Both valid after reset: req0 sub A=10,B=3; req1 slt A=32'hFFFFFFFF,B=1 -> req0 served first (result 7). Then req1 served (result 1, rsp_valid=10). The third contended grant returns to req0.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result stay constant, both req*_ready stay 0; completion occurs on the first rsp_ready[g]=1.
- Illegal code 4'b1111 from req1 with A=B=32'hDEADBEEF -> rsp_result=0, rsp_err=1; the next legal op returns rsp_err=0.
- rst_n pulsed low during EXEC -> outputs clear asynchronously and no response appears; the next request completes normally with pointer=0 priority.
- Wrong-bit ready: in RESP for req0, assert rsp_ready=10 -> no completion; then rsp_ready=01 -> back to IDLE.
